// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and field widths
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] form the synchronizer, [2] is the history flop for edge compares
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Idle bus reads high, so reset to 1 to avoid false edges after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    // SDA edges only count as START/STOP while SCL is stably high
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - 7-bit I2C slave with auto-incrementing byte register file
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h68,
    parameter int                    NUM_REGS   = 16,
    localparam int                   AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL,
    input  logic                  SDA_in,
    output logic                  SDA_out,
    output logic                  Tristate,
    output logic                  reg_wr,
    output logic [AW-1:0]         reg_wr_addr,
    output logic [I2C_BYTE_W-1:0] reg_wr_data,
    output logic                  busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (SCL),
        .sda       (SDA_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t            state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic [I2C_BYTE_W-1:0] shift, shift_nx;
    logic [AW-1:0]         ptr, ptr_nx, ptr_inc;
    logic                  rw, rw_nx;
    logic                  tri_nx, busy_nx, wr_en;
    logic [I2C_BYTE_W-1:0] byte_in;
    logic [I2C_BYTE_W-1:0] regs [NUM_REGS];

    assign SDA_out = 1'b0;
    assign byte_in = {shift[6:0], sda_s};
    // NUM_REGS is a power of two, so natural AW-bit overflow is the wrap
    assign ptr_inc = ptr + 1'b1;

    // Next-state logic: START/STOP override everything, then per-state bit handling
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_nx = shift;
        ptr_nx   = ptr;
        rw_nx    = rw;
        tri_nx   = Tristate;
        busy_nx  = busy;
        wr_en    = 1'b0;
        if (start_det) begin
            state_nx = ADDR;
            cnt_nx   = '0;
            tri_nx   = 1'b0;
        end else if (stop_det) begin
            state_nx = IDLE;
            tri_nx   = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR: begin
                    if (scl_rise) begin
                        shift_nx = byte_in;
                        cnt_nx   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_nx = '0;
                            if (state == ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_nx = ADDR_ACK;
                                    rw_nx    = byte_in[0];
                                    busy_nx  = 1'b1;
                                end else begin
                                    state_nx = IDLE;
                                end
                            end else if (state == PTR) begin
                                if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                                    ptr_nx   = byte_in[AW-1:0];
                                    state_nx = PTR_ACK;
                                end else begin
                                    state_nx = IDLE;
                                end
                            end else begin
                                wr_en    = 1'b1;
                                ptr_nx   = ptr_inc;
                                state_nx = WR_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    // First fall starts the ACK drive, the next fall ends it
                    if (scl_fall) begin
                        if (!Tristate) begin
                            tri_nx = 1'b1;
                        end else if (state == ADDR_ACK && rw) begin
                            state_nx = RD;
                            tri_nx   = ~regs[ptr][7];
                            shift_nx = {regs[ptr][6:0], 1'b0};
                            cnt_nx   = 4'd1;
                        end else begin
                            tri_nx   = 1'b0;
                            state_nx = (state == ADDR_ACK) ? PTR : WR;
                        end
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            tri_nx   = 1'b0;
                            cnt_nx   = '0;
                            state_nx = RD_ACK;
                        end else begin
                            tri_nx   = ~shift[7];
                            shift_nx = {shift[6:0], 1'b0};
                            cnt_nx   = cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_nx   = ptr_inc;
                            shift_nx = regs[ptr_inc];
                            cnt_nx   = '0;
                            state_nx = RD;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (state_nx == IDLE) busy_nx = 1'b0;
    end

    // State, datapath and register file update; reset releases SDA immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            Tristate    <= 1'b0;
            busy        <= 1'b0;
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shift    <= shift_nx;
            ptr      <= ptr_nx;
            rw       <= rw_nx;
            Tristate <= tri_nx;
            busy     <= busy_nx;
            reg_wr   <= wr_en;
            if (wr_en) begin
                regs[ptr]   <= byte_in;
                reg_wr_addr <= ptr;
                reg_wr_data <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - bus-level bench for i2c_slave_regs with write/read scoreboards
module tb_i2c_slave_regs;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic       SDA_out, Tristate, reg_wr, busy;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    int checks = 0;
    int errors = 0;
    int tri_cnt = 0;
    logic reg_wr_d = 1'b0;

    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];

    assign sda_bus = m_sda & ~Tristate;

    i2c_slave_regs #(.SLAVE_ADDR(7'h68), .NUM_REGS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .SCL         (scl),
        .SDA_in      (sda_bus),
        .SDA_out     (SDA_out),
        .Tristate    (Tristate),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Write scoreboard: each reg_wr pulse pops the oldest expected {addr,data}
    always @(negedge clk) begin
        if (Tristate) tri_cnt++;
        if (reg_wr && reg_wr_d) check("reg_wr_pulse_len", 2, 1);
        if (reg_wr && !reg_wr_d) begin
            if (wr_q.size() == 0) check("reg_wr_extra", 1, 0);
            else check("reg_wr", {reg_wr_addr, reg_wr_data}, wr_q.pop_front());
        end
        reg_wr_d <= reg_wr;
    end

    task automatic i2c_start();
        m_sda = 1'b1; #(T);
        scl   = 1'b1; #(T);
        m_sda = 1'b0; #(T);
        scl   = 1'b0; #(T);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(T);
        scl   = 1'b1; #(T);
        m_sda = 1'b1; #(T);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; #(T);
        scl   = 1'b1; #(2*T);
        scl   = 1'b0; #(T);
    endtask

    task automatic read_bit(output logic r);
        m_sda = 1'b1; #(T);
        scl   = 1'b1; #(T);
        r     = sda_bus; #(T);
        scl   = 1'b0; #(T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] b;
        logic       r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            b[i] = r;
        end
        write_bit(nack);
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_data", b, rd_q.pop_front());
    endtask

    initial begin
        logic a, r;
        int   c0;
        reset = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        #(2*T);
        check("rst_tristate", Tristate, 0);
        check("rst_sda_out", SDA_out, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_wr_addr", reg_wr_addr, 0);
        check("rst_wr_data", reg_wr_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        #(2*T);

        // Burst write 0xA5,0x5A starting at register 3
        i2c_start();
        write_byte(8'hD0, a); check("t1_addr_ack", a, 0);
        check("t1_busy", busy, 1);
        write_byte(8'h03, a); check("t1_ptr_ack", a, 0);
        wr_q.push_back({4'd3, 8'hA5});
        write_byte(8'hA5, a); check("t1_d0_ack", a, 0);
        wr_q.push_back({4'd4, 8'h5A});
        write_byte(8'h5A, a); check("t1_d1_ack", a, 0);
        i2c_stop();
        check("t1_busy_stop", busy, 0);
        check("t1_wr_q", wr_q.size(), 0);

        // Pointer write, repeated START, burst read with final NACK
        i2c_start();
        write_byte(8'hD0, a); check("t2_addr_ack", a, 0);
        write_byte(8'h03, a); check("t2_ptr_ack", a, 0);
        i2c_start();
        write_byte(8'hD1, a); check("t2_raddr_ack", a, 0);
        rd_q.push_back(8'hA5); read_byte(1'b0);
        rd_q.push_back(8'h5A); read_byte(1'b1);
        #(T);
        check("t2_tri_nack", Tristate, 0);
        i2c_stop();
        check("t2_busy_stop", busy, 0);

        // Foreign address: never driven, never written
        c0 = tri_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("t3_addr_nack", a, 1);
        write_byte(8'h55, a); check("t3_data_nack", a, 1);
        i2c_stop();
        check("t3_tri_never", tri_cnt - c0, 0);
        check("t3_busy", busy, 0);

        // Pointer wrap at the last register, then out-of-range pointer
        i2c_start();
        write_byte(8'hD0, a); check("t4_addr_ack", a, 0);
        write_byte(8'h0F, a); check("t4_ptr_ack", a, 0);
        wr_q.push_back({4'd15, 8'h11});
        write_byte(8'h11, a); check("t4_d0_ack", a, 0);
        wr_q.push_back({4'd0, 8'h22});
        write_byte(8'h22, a); check("t4_d1_ack", a, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, a);
        write_byte(8'h0F, a);
        i2c_start();
        write_byte(8'hD1, a); check("t4_raddr_ack", a, 0);
        rd_q.push_back(8'h11); read_byte(1'b0);
        rd_q.push_back(8'h22); read_byte(1'b1);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, a); check("t4_bad_addr_ack", a, 0);
        write_byte(8'h10, a); check("t4_bad_ptr_nack", a, 1);
        write_byte(8'h77, a); check("t4_after_nack", a, 1);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, a);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'hD1, a);
        rd_q.push_back(8'h22); read_byte(1'b1);
        i2c_stop();
        check("t4_wr_q", wr_q.size(), 0);

        // STOP after half a data byte aborts the write
        i2c_start();
        write_byte(8'hD0, a);
        write_byte(8'h05, a); check("t5_ptr_ack", a, 0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check("t5_busy", busy, 0);
        i2c_start();
        write_byte(8'hD0, a); check("t5_next_addr_ack", a, 0);
        write_byte(8'h05, a);
        i2c_start();
        write_byte(8'hD1, a);
        rd_q.push_back(8'h00); read_byte(1'b1);
        i2c_stop();

        // Reset while the slave pulls SDA low for a 0 read bit
        i2c_start();
        write_byte(8'hD0, a);
        write_byte(8'h02, a);
        i2c_start();
        write_byte(8'hD1, a); check("t6_raddr_ack", a, 0);
        read_bit(r); check("t6_bit7", r, 0);
        check("t6_tri_driving", Tristate, 1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_tri_reset", Tristate, 0);
        #6;
        scl   = 1'b1;
        m_sda = 1'b1;
        #(2*T);
        check("t6_busy_reset", busy, 0);
        reset = 1'b1;
        #(2*T);
        i2c_start();
        write_byte(8'hD0, a); check("t6_post_addr_ack", a, 0);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'hD1, a);
        for (int i = 0; i < 16; i++) begin
            rd_q.push_back(8'h00);
            read_byte(i == 15);
        end
        i2c_stop();
        check("t6_rd_q", rd_q.size(), 0);
        check("end_wr_q", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
